dataframe_store_nshot: RTL and testbench
========================================

Name: dataframe_store_nshot

Overview:
Single-clock, parametrised capture buffer for wide uplink data frames. Stores accepted frames in an internal FIFO of DEPTH entries. Frames are read back as WORD_W-bit words through a register-style strobe/index port driven by the AXI4-Lite register decoder. Adds continuous and N-shot capture modes, overflow accounting, occupancy reporting and a clear command to the single-mode, fixed-width dataframe store.

Parameters:
FRAME_W, 234, frame width in bits
WORD_W, 32, readout word width
DEPTH, 16, FIFO depth in frames; power of 2, >=2
CNT_W, 16, width of frame/overflow counters and N-shot target
NWORDS (localparam), ceil(FRAME_W/WORD_W) (+1 with FRAME_TIMESTAMP_EN), words per frame
IDX_W (localparam), $clog2(NWORDS+1), width of the readout word index

Ports:
S_AXI_ACLK  in  1  sole clock
S_AXI_ARESETN  in  1  reset; synchronous, active-low
frame_i  in  FRAME_W  incoming frame
frame_valid_i  in  1  frame_i valid this cycle
cfg_enable_i  in  1  level; capture enabled
cfg_mode_i  in  1  0=continuous, 1=N-shot
cfg_nshot_i  in  CNT_W  frames to store in N-shot mode
cfg_clear_i  in  1  pulse; flush FIFO, zero counters, return to IDLE
rd_strobe_i  in  1  one-cycle read request
rd_idx_i  in  IDX_W  word index within head frame
rd_data_o  out  WORD_W  registered read word
empty_o  out  1  FIFO empty
full_o  out  1  FIFO full
level_o  out  $clog2(DEPTH)+1  frames stored
frame_cnt_o  out  CNT_W  frames stored since clear; saturating
overflow_cnt_o  out  CNT_W  frames dropped while full; saturating
done_o  out  1  N-shot target reached

Behaviour:
- Reset (S_AXI_ARESETN=0 at clock edge): state IDLE; FIFO empty. rd_data_o, level_o, frame_cnt_o, overflow_cnt_o and done_o are 0; empty_o=1, full_o=0.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE -> CAPTURE when cfg_enable_i=1.
  - CAPTURE -> IDLE when cfg_enable_i=0.
  - CAPTURE -> DONE when cfg_mode_i=1 and frame_cnt_o reaches cfg_nshot_i (the cycle after the Nth store).
  - DONE -> IDLE when cfg_enable_i=0.
- cfg_nshot_i=0 in N-shot mode: CAPTURE -> DONE on the first CAPTURE cycle; nothing is stored.
- done_o=1 only in DONE.
- cfg_clear_i has priority over reset-free logic. It sets pointers, level, counters and rd_data_o to 0 and the state to IDLE in one cycle. A frame or strobe in the same cycle is ignored.
- Accept: frame_valid_i=1 in CAPTURE.
  - Accepted and (not full, or pop in the same cycle): store the frame and increment frame_cnt_o.
  - Accepted and full with no pop: drop the frame and increment overflow_cnt_o. The frame does not count toward N.
  - Counters saturate at 2^CNT_W-1.
- Read: on rd_strobe_i, rd_data_o <= word rd_idx_i of the head frame, one-cycle latency.
  - Word k = frame bits [k*WORD_W +: WORD_W]; bits at or above FRAME_W read as 0.
  - rd_idx_i >= NWORDS, or FIFO empty: rd_data_o <= 0.
  - rd_data_o holds its value between strobes.
- Pop: rd_strobe_i=1, rd_idx_i=NWORDS-1 and not empty. Head advances after the read word is captured. One strobe gives at most one pop, so the register decoder must deliver a single-cycle strobe per AXI read.
- Simultaneous push and pop: both take effect; level_o is unchanged. Pop on empty is ignored.
- Pointers wrap modulo DEPTH. full_o/empty_o/level_o are derived from registered pointers and are valid the cycle after each update.

Optional Feature:
FRAME_TIMESTAMP_EN.
- Defined: a free-running 32-bit cycle counter runs from reset (zeroed by clear). Its value at the accept cycle is stored with each frame as word NWORDS-1. That word is the pop word; NWORDS includes it.
- Undefined: no counter; NWORDS=ceil(FRAME_W/WORD_W).

Decomposition:
- Package dataframe_store_pkg: state enum (IDLE/CAPTURE/DONE), mode enum (CONTINUOUS/NSHOT), function words_for(frame_w, word_w).
- Sub-module frame_fifo_sc: single-clock FIFO with parametrised width and depth, push/pop, level, full, empty; inferred RAM. The FSM, counters and word mux stay in the top.

Test Plan:
- Continuous mode, enable, 3 valid frames, read words 0..7 per frame -> frames return in order; 234-bit frame word 7 = {22'b0, frame[233:224]}; level_o 3 -> 0; empty_o=1.
- DEPTH=16, 20 frames with no reads -> level_o=16, full_o=1, frame_cnt_o=16, overflow_cnt_o=4; first 16 frames retained.
- N-shot, cfg_nshot_i=5, 8 consecutive frames -> exactly 5 stored; done_o=1 from the cycle after the 5th; deassert enable -> IDLE, done_o=0.
- Full FIFO, push and pop in the same cycle -> level_o stays 16, overflow_cnt_o unchanged, new frame at the tail.
- rd_idx_i=9 read, or read while empty -> rd_data_o=0, no pop; cfg_clear_i while frames present -> level_o=0, counters 0, state IDLE.
- FRAME_TIMESTAMP_EN defined, frames accepted at cycles t and t+3 -> word NWORDS-1 differs by 3; reading it pops the frame.

Source files
------------

// File: rtl/dataframe_store_pkg.sv
// Shared types and helpers for the dataframe capture store.
package dataframe_store_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  typedef enum logic {
    CONTINUOUS = 1'b0,
    NSHOT      = 1'b1
  } mode_e;

  function automatic int words_for(int frame_w, int word_w);
    return (frame_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/dataframe_store_nshot_fifo.sv
// Single-clock frame FIFO; power-of-2 depth, pointers carry a wrap bit.
module frame_fifo_sc #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             push_ok, pop_ok;

  assign level_o = wptr_q - rptr_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // a push into a full FIFO is legal when the head leaves the same cycle
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/dataframe_store_nshot.sv
// Frame capture store with continuous / N-shot modes and word readout.
// Optional FRAME_TIMESTAMP_EN appends a cycle-count word to each frame.
module dataframe_store_nshot
  import dataframe_store_pkg::*;
#(
  parameter  int FRAME_W = 234,
  parameter  int WORD_W  = 32,
  parameter  int DEPTH   = 16,
  parameter  int CNT_W   = 16,
`ifdef FRAME_TIMESTAMP_EN
  localparam int NWORDS  = words_for(FRAME_W, WORD_W) + 1,
`else
  localparam int NWORDS  = words_for(FRAME_W, WORD_W),
`endif
  localparam int IDX_W   = $clog2(NWORDS + 1),
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               frame_valid_i,
  input  logic               cfg_enable_i,
  input  logic               cfg_mode_i,
  input  logic [CNT_W-1:0]   cfg_nshot_i,
  input  logic               cfg_clear_i,
  input  logic               rd_strobe_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [WORD_W-1:0]  rd_data_o,
  output logic               empty_o,
  output logic               full_o,
  output logic [LVL_W-1:0]   level_o,
  output logic [CNT_W-1:0]   frame_cnt_o,
  output logic [CNT_W-1:0]   overflow_cnt_o,
  output logic               done_o
);

  localparam int SW = NWORDS * WORD_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;
  logic [WORD_W-1:0] rd_q, rd_d;
  logic [WORD_W-1:0] word;
  logic [SW-1:0]     wr_data, head;
  logic              full, empty;
  logic              nshot_hit, accept, pop, push, drop;

`ifdef FRAME_TIMESTAMP_EN
  localparam int FW_PAD = words_for(FRAME_W, WORD_W) * WORD_W;
  logic [31:0] ts_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN || cfg_clear_i) ts_q <= '0;
    else                               ts_q <= ts_q + 1'b1;
  end

  assign wr_data = {WORD_W'(ts_q), FW_PAD'(frame_i)};
`else
  assign wr_data = SW'(frame_i);
`endif

  // once the target is met no further frame may enter, even for one cycle
  assign nshot_hit = (mode_e'(cfg_mode_i) == NSHOT) &&
                     (cnt_q >= cfg_nshot_i);
  assign accept = (state_q == CAPTURE) & frame_valid_i &
                  ~nshot_hit & ~cfg_clear_i;
  assign pop    = rd_strobe_i & ~empty & ~cfg_clear_i &
                  (rd_idx_i == IDX_W'(NWORDS - 1));
  assign push   = accept & (~full | pop);
  assign drop   = accept & full & ~pop;

  frame_fifo_sc #(
    .WIDTH (SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .clr_i   (cfg_clear_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wr_data),
    .head_o  (head),
    .level_o (level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (rd_idx_i == IDX_W'(k)) word = head[k*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rd_d    = rd_q;
    state_d = state_q;
    if (push && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    if (drop && ovf_q != '1) ovf_d = ovf_q + 1'b1;
    if (rd_strobe_i) rd_d = empty ? '0 : word;
    unique case (state_q)
      IDLE:    if (cfg_enable_i) state_d = CAPTURE;
      CAPTURE: begin
        if (!cfg_enable_i) state_d = IDLE;
        else if (mode_e'(cfg_mode_i) == NSHOT &&
                 cnt_d >= cfg_nshot_i) state_d = DONE;
      end
      DONE:    if (!cfg_enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cfg_clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      ovf_d   = '0;
      rd_d    = '0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
    end
  end

  assign rd_data_o      = rd_q;
  assign empty_o        = empty;
  assign full_o         = full;
  assign frame_cnt_o    = cnt_q;
  assign overflow_cnt_o = ovf_q;
  assign done_o         = (state_q == DONE);

endmodule

// File: tb/tb_dataframe_store_nshot.sv
// Randomised bench for dataframe_store_nshot against a queue-based model.
module tb_dataframe_store_nshot;

  localparam int FW = 234;
  localparam int NW = 8;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] frame;
  logic          fvalid, en, mode, clr, strobe;
  logic [15:0]   nshot;
  logic [3:0]    idx;
  logic [31:0]   rd_data;
  logic          empty, full, done;
  logic [4:0]    level;
  logic [15:0]   fcnt, ocnt;

  always #5 clk = ~clk;

  dataframe_store_nshot dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESETN  (rst_n),
    .frame_i        (frame),
    .frame_valid_i  (fvalid),
    .cfg_enable_i   (en),
    .cfg_mode_i     (mode),
    .cfg_nshot_i    (nshot),
    .cfg_clear_i    (clr),
    .rd_strobe_i    (strobe),
    .rd_idx_i       (idx),
    .rd_data_o      (rd_data),
    .empty_o        (empty),
    .full_o         (full),
    .level_o        (level),
    .frame_cnt_o    (fcnt),
    .overflow_cnt_o (ocnt),
    .done_o         (done)
  );

  bit [FW-1:0] mq[$];
  int          m_cnt, m_ovf, m_st;
  logic [31:0] m_rd;
  int          n_chk = 0;
  int          n_fail = 0;

  wire [71:0] dut_vec = {rd_data, level, empty, full, fcnt, ocnt, done};

  function automatic logic [31:0] word_of(bit [FW-1:0] f, int k);
    logic [255:0] x;
    x = 256'(f);
    return x[k*32 +: 32];
  endfunction

  function automatic logic [71:0] exp_vec();
    return {m_rd, 5'(mq.size()), mq.size() == 0, mq.size() == D,
            16'(m_cnt), 16'(m_ovf), m_st == 2};
  endfunction

  function automatic bit [FW-1:0] rnd_frame();
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    return FW'(x);
  endfunction

  // apply the rules of one clock edge to the model, then settle
  task automatic tick();
    bit p;
    bit hit;
    @(posedge clk);
    if (!rst_n || clr) begin
      mq.delete();
      m_cnt = 0; m_ovf = 0; m_rd = 0; m_st = 0;
    end else begin
      p   = strobe && idx == NW - 1 && mq.size() > 0;
      hit = mode && m_cnt >= int'(nshot);
      if (strobe)
        m_rd = (mq.size() > 0 && idx < NW) ? word_of(mq[0], idx) : 32'h0;
      if (m_st == 1 && fvalid && !hit) begin
        if (mq.size() < D || p) begin
          if (p) begin void'(mq.pop_front()); p = 0; end
          mq.push_back(frame);
          if (m_cnt < 65535) m_cnt++;
        end else if (m_ovf < 65535) m_ovf++;
      end
      if (p) void'(mq.pop_front());
      case (m_st)
        0: if (en) m_st = 1;
        1: if (!en) m_st = 0;
           else if (mode && m_cnt >= int'(nshot)) m_st = 2;
        default: if (!en) m_st = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    fvalid = 0; strobe = 0; clr = 0; idx = 0;
  endtask

  task automatic do_clear();
    quiet();
    clr = 1; tick(); clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1; fvalid = 1; frame = rnd_frame();
    strobe = 1; idx = 0; mode = 0; nshot = 0; clr = 0;
    tick(); tick();
    n_chk++;
    if (dut_vec !== {32'h0, 5'd0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
      $display("FAIL reset got %h want empty-only", dut_vec);
      n_fail++;
    end
    rst_n = 1; quiet(); en = 0; tick();
  endtask

  task automatic test_continuous();
    do_clear();
    mode = 0; en = 1; tick();
    for (int i = 0; i < 3; i++) begin
      fvalid = 1; frame = rnd_frame(); tick();
    end
    fvalid = 0; tick();
    n_chk++;
    if (level !== 5'd3 || dut_vec !== exp_vec()) begin
      $display("FAIL cont_level got %h want %h", dut_vec, exp_vec());
      n_fail++;
    end
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NW; k++) begin
        strobe = 1; idx = 4'(k); tick();
        n_chk++;
        if (dut_vec !== exp_vec()) begin
          $display("FAIL cont_read f%0d w%0d got %h want %h",
                   f, k, dut_vec, exp_vec());
          n_fail++;
        end
        if (k == NW - 1) begin
          n_chk++;
          if (rd_data[31:10] !== 22'h0) begin
            $display("FAIL cont_pad got %h want upper 22 bits 0", rd_data);
            n_fail++;
          end
        end
      end
    end
    strobe = 0; tick();
    n_chk++;
    if (empty !== 1'b1 || level !== 5'd0) begin
      $display("FAIL cont_empty got e=%b l=%0d want e=1 l=0", empty, level);
      n_fail++;
    end
  endtask

  task automatic test_overflow();
    bit [FW-1:0] first;
    do_clear();
    mode = 0; en = 1; tick();
    for (int i = 0; i < 20; i++) begin
      fvalid = 1; frame = rnd_frame();
      if (i == 0) first = frame;
      tick();
    end
    fvalid = 0; tick();
    n_chk++;
    if ({level, full, fcnt, ocnt} !== {5'd16, 1'b1, 16'd16, 16'd4} ||
        dut_vec !== exp_vec()) begin
      $display("FAIL overflow got %h want %h", dut_vec, exp_vec());
      n_fail++;
    end
    strobe = 1; idx = 0; tick(); strobe = 0;
    n_chk++;
    if (rd_data !== word_of(first, 0)) begin
      $display("FAIL ovf_head got %h want %h", rd_data, word_of(first, 0));
      n_fail++;
    end
  endtask

  task automatic test_push_pop_full();
    bit [FW-1:0] newf;
    newf = rnd_frame();
    fvalid = 1; frame = newf; strobe = 1; idx = 7; tick();
    quiet(); en = 0; tick();
    n_chk++;
    if ({level, ocnt, fcnt} !== {5'd16, 16'd4, 16'd17} ||
        dut_vec !== exp_vec()) begin
      $display("FAIL pushpop got %h want %h", dut_vec, exp_vec());
      n_fail++;
    end
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < NW; k++) begin
        strobe = 1; idx = 4'(k); tick();
        n_chk++;
        if (dut_vec !== exp_vec()) begin
          $display("FAIL drain f%0d w%0d got %h want %h",
                   f, k, dut_vec, exp_vec());
          n_fail++;
        end
        if (f == 15 && k == 0) begin
          n_chk++;
          if (rd_data !== word_of(newf, 0)) begin
            $display("FAIL tail got %h want %h", rd_data, word_of(newf, 0));
            n_fail++;
          end
        end
      end
    end
    quiet();
  endtask

  task automatic test_nshot();
    do_clear();
    en = 0; mode = 1; nshot = 5; tick();
    en = 1; tick();
    for (int i = 0; i < 8; i++) begin
      fvalid = 1; frame = rnd_frame(); tick();
      n_chk++;
      if (done !== (i >= 4) || dut_vec !== exp_vec()) begin
        $display("FAIL nshot step%0d got %h want %h done=%0d",
                 i, dut_vec, exp_vec(), i >= 4);
        n_fail++;
      end
    end
    fvalid = 0; tick();
    n_chk++;
    if ({fcnt, level, done, ocnt} !== {16'd5, 5'd5, 1'b1, 16'd0}) begin
      $display("FAIL nshot_final got %h want cnt5 lvl5 done", dut_vec);
      n_fail++;
    end
    en = 0; tick();
    n_chk++;
    if (done !== 1'b0 || dut_vec !== exp_vec()) begin
      $display("FAIL nshot_off got %h want %h", dut_vec, exp_vec());
      n_fail++;
    end
  endtask

  task automatic test_nshot_zero();
    do_clear();
    mode = 1; nshot = 0; en = 1; tick();
    fvalid = 1; frame = rnd_frame(); tick(); tick(); fvalid = 0;
    n_chk++;
    if ({level, fcnt, done} !== {5'd0, 16'd0, 1'b1} ||
        dut_vec !== exp_vec()) begin
      $display("FAIL nshot0 got %h want %h", dut_vec, exp_vec());
      n_fail++;
    end
    en = 0; mode = 0; tick();
  endtask

  task automatic test_bad_idx();
    do_clear();
    mode = 0; en = 1; tick();
    for (int i = 0; i < 2; i++) begin
      fvalid = 1; frame = rnd_frame(); tick();
    end
    fvalid = 0; en = 0;
    strobe = 1; idx = 0; tick();
    idx = 9; tick();
    n_chk++;
    if ({rd_data, level} !== {32'h0, 5'd2} || dut_vec !== exp_vec()) begin
      $display("FAIL idx9 got %h want %h", dut_vec, exp_vec());
      n_fail++;
    end
    idx = 8; tick();
    n_chk++;
    if ({rd_data, level} !== {32'h0, 5'd2}) begin
      $display("FAIL idx8 got %h/%0d want 0/2", rd_data, level);
      n_fail++;
    end
    strobe = 0; do_clear();
    strobe = 1; idx = 7; tick(); strobe = 0;
    n_chk++;
    if ({rd_data, level, empty} !== {32'h0, 5'd0, 1'b1}) begin
      $display("FAIL rd_empty got %h want 0", dut_vec);
      n_fail++;
    end
  endtask

  task automatic test_clear();
    do_clear();
    mode = 0; en = 1; tick();
    for (int i = 0; i < 3; i++) begin
      fvalid = 1; frame = rnd_frame(); tick();
    end
    strobe = 1; idx = 1; tick();
    clr = 1; fvalid = 1; idx = 7; tick();
    quiet(); en = 0; tick();
    n_chk++;
    if (dut_vec !== {32'h0, 5'd0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0} ||
        dut_vec !== exp_vec()) begin
      $display("FAIL clear got %h want all-zero empty", dut_vec);
      n_fail++;
    end
  endtask

  task automatic test_random();
    do_clear();
    mode = 0; nshot = 6;
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) begin
        mode  = $urandom_range(0, 1);
        nshot = 16'($urandom_range(0, 20));
      end
      en     = ($urandom_range(0, 9) != 0);
      clr    = ($urandom_range(0, 99) == 0);
      fvalid = $urandom_range(0, 1);
      frame  = rnd_frame();
      strobe = ($urandom_range(0, 9) < 3);
      idx    = ($urandom_range(0, 2) == 0) ? 4'd7 : 4'($urandom_range(0, 9));
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL random c%0d got %h want %h", c, dut_vec, exp_vec());
        n_fail++;
      end
    end
    quiet();
  endtask

  initial begin
    quiet();
    test_reset();
    test_continuous();
    test_overflow();
    test_push_pop_full();
    test_nshot();
    test_nshot_zero();
    test_bad_idx();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
